btb_update_queue: RTL and testbench

//  Buffers resolved-branch BTB updates from the backend and drains them, one per cycle,

---
 rtl/btb_updq_pkg.sv | 19 +
 rtl/btb_updq_ptr.sv | 45 ++++
 rtl/btb_update_queue.sv | 178 +++++++++++++++++
 tb/tb_btb_update_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_updq_pkg.sv
// Shared types for the BTB update queue.
//
// btb_update_t is one resolved-branch update as stored in the queue. The
// address fields are sized by VADDR_W_DEF, which is the widest address the
// queue supports. The top module's VADDR_W parameter may be narrower; narrower
// addresses are zero-extended into these fields on write and sliced back out
// on read.
package btb_updq_pkg;

  localparam int VADDR_W_DEF = 64;

  typedef struct packed {
    logic [VADDR_W_DEF-1:0] pc;
    logic [VADDR_W_DEF-1:0] target;
    logic                   is_br;
    logic                   is_jal;
  } btb_update_t;

endpackage

// File: rtl/btb_updq_ptr.sv
// Wrap-around index pointer for the BTB update queue.
//
// The pointer counts 0 .. DEPTH-1 and then returns to 0. A clear request
// takes priority over an increment request.
//
// Ports:
//   clock   : clock; all state changes on its rising edge
//   reset   : asynchronous, active-high; forces the pointer to 0
//   clr_i   : force the pointer to 0 on the next edge
//   incr_i  : advance the pointer by one, wrapping at DEPTH-1
//   ptr_o   : current pointer value
module btb_updq_ptr #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             incr_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (incr_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/btb_update_queue.sv
// BTB update queue.
//
// Buffers resolved-branch BTB updates from the backend and drains them, at
// most one per cycle, into the single BTB update port. A flush drops every
// queued update.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge;
// valid and its payload must not depend on ready from the same side, and
// enq_ready depends only on registered state and enq_pc (never on
// update_ready).
//
// Optional feature macro: BTB_UPDQ_COALESCE_EN. When defined, an enqueue
// whose pc matches the youngest queued entry overwrites that entry instead
// of allocating a new one, and is accepted even when the queue is full.
//
// Ports:
//   clock, reset              : clock and asynchronous active-high reset
//   enq_valid / enq_ready     : enqueue handshake from the backend
//   enq_pc, enq_target        : branch pc and resolved target
//   enq_is_br, enq_is_jal     : branch kind
//   flush                     : drop all queued updates (highest priority)
//   update_valid/update_ready : dequeue handshake toward the BTB
//   update_pc, update_target  : head entry pc and target
//   update_is_br, update_is_jal : head entry branch kind
//   count                     : current occupancy
//   drop_err                  : sticky, enqueue attempted while not ready
module btb_update_queue
  import btb_updq_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int VADDR_W = VADDR_W_DEF,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [VADDR_W-1:0] enq_pc,
  input  logic [VADDR_W-1:0] enq_target,
  input  logic               enq_is_br,
  input  logic               enq_is_jal,
  input  logic               flush,
  output logic               update_valid,
  input  logic               update_ready,
  output logic [VADDR_W-1:0] update_pc,
  output logic [VADDR_W-1:0] update_target,
  output logic               update_is_br,
  output logic               update_is_jal,
  output logic [CNT_W-1:0]   count,
  output logic               drop_err
);

  btb_update_t      mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             drop_err_q;
  logic             drop_err_d;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] youngest;
  logic [PTR_W-1:0] wr_idx;

  logic        full;
  logic        empty;
  logic        enq_fire;
  logic        pop_fire;
  logic        coal_match;
  logic        coal_hit;
  logic        alloc;
  logic        wr_en;
  logic        head_incr;
  btb_update_t wr_entry;
  btb_update_t head_entry;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // DEPTH is a power of two, so the natural wrap of the subtraction gives
  // the slot written most recently.
  assign youngest = tail - PTR_W'(1);

`ifdef BTB_UPDQ_COALESCE_EN
  // The pc match alone decides readiness so enq_ready stays independent of
  // update_ready. When full, the youngest entry cannot be the head
  // (DEPTH >= 2), so the pop exclusion below never retracts a readiness
  // granted on a full queue.
  assign coal_match = !empty && (mem_q[youngest].pc[VADDR_W-1:0] == enq_pc);
  // A lone entry that is leaving this cycle is not overwritten; the new
  // update allocates behind it instead.
  assign coal_hit   = coal_match && !((count_q == CNT_W'(1)) && pop_fire);
`else
  assign coal_match = 1'b0;
  assign coal_hit   = 1'b0;
`endif

  assign enq_ready    = !full || coal_match;
  assign update_valid = !empty;
  assign enq_fire     = enq_valid && enq_ready;
  assign pop_fire     = update_valid && update_ready;

  // A flush discards both the enqueue and the pop of its own cycle.
  assign wr_en     = enq_fire && !flush;
  assign alloc     = wr_en && !coal_hit;
  assign head_incr = pop_fire && !flush;
  assign wr_idx    = coal_hit ? youngest : tail;

  always_comb begin
    wr_entry        = '0;
    wr_entry.pc     = VADDR_W_DEF'(enq_pc);
    wr_entry.target = VADDR_W_DEF'(enq_target);
    wr_entry.is_br  = enq_is_br;
    wr_entry.is_jal = enq_is_jal;
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({alloc, head_incr})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  assign drop_err_d = drop_err_q || (enq_valid && !enq_ready && !flush);

  btb_updq_ptr #(.DEPTH(DEPTH)) u_head_ptr (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (flush),
    .incr_i (head_incr),
    .ptr_o  (head)
  );

  btb_updq_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (flush),
    .incr_i (alloc),
    .ptr_o  (tail)
  );

  // Storage is reset so the update_* outputs read zero straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign head_entry    = mem_q[head];
  assign update_pc     = head_entry.pc[VADDR_W-1:0];
  assign update_target = head_entry.target[VADDR_W-1:0];
  assign update_is_br  = head_entry.is_br;
  assign update_is_jal = head_entry.is_jal;
  assign count         = count_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Testbench for btb_update_queue.
//
// The reference model is a queue of expected entries {pc, target, is_br,
// is_jal}. The driver applies inputs just after a rising edge, decides from
// the model what the coming edge should do, and updates the model after the
// monitor has looked at the head. The monitor runs on the falling edge,
// compares the DUT outputs with the model, and pops the model head whenever
// the BTB side consumes an entry.
module tb_btb_update_queue;

  localparam int DEPTH = 8;
  localparam int VW    = 64;
  localparam int CW    = 4;
  localparam int EW    = 2 * VW + 2;

`ifdef BTB_UPDQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          enq_valid;
  logic          enq_ready;
  logic [VW-1:0] enq_pc;
  logic [VW-1:0] enq_target;
  logic          enq_is_br;
  logic          enq_is_jal;
  logic          flush;
  logic          update_valid;
  logic          update_ready;
  logic [VW-1:0] update_pc;
  logic [VW-1:0] update_target;
  logic          update_is_br;
  logic          update_is_jal;
  logic [CW-1:0] count;
  logic          drop_err;

  logic [EW-1:0] exp_q[$];
  logic          model_ready;
  logic          model_drop;
  int            n_checks;
  int            n_errors;

  btb_update_queue #(.DEPTH(DEPTH), .VADDR_W(VW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_pc        (enq_pc),
    .enq_target    (enq_target),
    .enq_is_br     (enq_is_br),
    .enq_is_jal    (enq_is_jal),
    .flush         (flush),
    .update_valid  (update_valid),
    .update_ready  (update_ready),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_is_br  (update_is_br),
    .update_is_jal (update_is_jal),
    .count         (count),
    .drop_err      (drop_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      logic [EW-1:0] head;
      check("count", VW'(count), VW'(exp_q.size()));
      check("enq_ready", VW'(enq_ready), VW'(model_ready));
      check("drop_err", VW'(drop_err), VW'(model_drop));
      check("update_valid", VW'(update_valid), VW'(exp_q.size() != 0));
      if (update_valid && exp_q.size() != 0) begin
        head = exp_q[0];
        check("update_pc", update_pc, head[EW-1 -: VW]);
        check("update_target", update_target, head[VW+1 -: VW]);
        check("update_is_br", VW'(update_is_br), VW'(head[1]));
        check("update_is_jal", VW'(update_is_jal), VW'(head[0]));
        if (update_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic ev, input logic [VW-1:0] pc, input logic [VW-1:0] tgt,
                       input logic br, input logic jal, input logic ur, input logic fl);
    logic [EW-1:0] ent;
    logic [EW-1:0] last;
    logic          match;
    logic          hit;
    enq_valid    = ev;
    enq_pc       = pc;
    enq_target   = tgt;
    enq_is_br    = br;
    enq_is_jal   = jal;
    update_ready = ur;
    flush        = fl;
    ent   = {pc, tgt, br, jal};
    match = 1'b0;
    if (COAL && exp_q.size() != 0) begin
      last  = exp_q[exp_q.size()-1];
      match = (last[EW-1 -: VW] == pc);
    end
    model_ready = (exp_q.size() != DEPTH) || match;
    hit = match && !(exp_q.size() == 1 && ur);
    @(negedge clock);
    #1;
    if (fl) begin
      exp_q.delete();
    end else if (ev && model_ready) begin
      if (hit) exp_q[exp_q.size()-1] = ent;
      else     exp_q.push_back(ent);
    end
    if (ev && !model_ready && !fl) model_drop = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ur, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, ur, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_update_valid"}, VW'(update_valid), '0);
    check({tag, "_count"}, VW'(count), '0);
    check({tag, "_enq_ready"}, VW'(enq_ready), VW'(1));
    check({tag, "_drop_err"}, VW'(drop_err), '0);
    check({tag, "_update_pc"}, update_pc, '0);
    check({tag, "_update_target"}, update_target, '0);
    check({tag, "_update_is_br"}, VW'(update_is_br), '0);
    check({tag, "_update_is_jal"}, VW'(update_is_jal), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_ready  = 1'b1;
    model_drop   = 1'b0;
    reset        = 1'b1;
    enq_valid    = 1'b0;
    enq_pc       = '0;
    enq_target   = '0;
    enq_is_br    = 1'b0;
    enq_is_jal   = 1'b0;
    flush        = 1'b0;
    update_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: single update, visible one cycle later, drained at once
    drive(1'b1, 64'h1000, 64'h2000, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_valid_next", VW'(update_valid), VW'(1));
    check("t1_pc_next", update_pc, 64'h1000);
    idle(1'b1, 2);

    // 2: fill while stalled, overflow enqueue is dropped
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 64'h100 * (i + 1), 64'h9000 + i, i[0], i[1], 1'b0, 1'b0);
    check("t2_full_count", VW'(count), VW'(DEPTH));
    check("t2_full_ready", VW'(enq_ready), '0);
    drive(1'b1, 64'hdead0, 64'hbeef, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_drop_err", VW'(drop_err), VW'(1));

    // 3: full with enqueue and pop in the same cycle: enqueue still refused
    drive(1'b1, 64'h7777, 64'h8888, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_count", VW'(count), VW'(DEPTH - 1));
    idle(1'b1, DEPTH);
    check("t3_drained", VW'(count), '0);

    // 4: flush at count 3 discards the flush-cycle enqueue
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h500 + i, 64'h600 + i, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h5555, 64'h6666, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t4_count", VW'(count), '0);
    check("t4_valid", VW'(update_valid), '0);
    check("t4_drop_kept", VW'(drop_err), VW'(1));
    idle(1'b0, 1);

    // 5: same pc enqueued twice while stalled
    drive(1'b1, 64'h40, 64'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h40, 64'hc0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef BTB_UPDQ_COALESCE_EN
    check("t5_count", VW'(count), VW'(1));
    check("t5_head_tgt", update_target, 64'hc0);
`else
    check("t5_count", VW'(count), VW'(2));
    check("t5_head_tgt", update_target, 64'h80);
`endif
    idle(1'b1, 3);

    // 6: asynchronous reset in the middle of a drain
    for (int i = 0; i < 5; i++) drive(1'b1, 64'ha00 + i, 64'hb00 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    update_ready = 1'b1;
    enq_valid    = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    model_drop  = 1'b0;
    model_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // random traffic over a small pc pool so repeats occur
    for (int n = 0; n < 600; n++) begin
      logic [VW-1:0] pc;
      logic [VW-1:0] tgt;
      pc  = VW'($urandom_range(1, 6)) << 4;
      tgt = {$urandom(), $urandom()};
      drive($urandom_range(0, 9) < 7, pc, tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 5, $urandom_range(0, 99) < 3);
    end
    idle(1'b1, DEPTH + 2);
    check("final_empty", VW'(count), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
